mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Sequential add-shift controller for the signed 8×8 multiplier. It owns the A/B/X/S operand registers and the control state machine, and drives the 9-bit ripple adder's `x`, `y` and `z` inputs. It captures the adder's sum `s` each add step and produces a 16-bit two's-complement product after eight add/shift iterations. The final iteration subtracts, to account for the multiplier's sign bit.

## Interface
- `WIDTH`, default 8: operand width. The adder interface is `WIDTH+1` bits and the product is `2*WIDTH` bits.
- `Clk`  in  1: sole clock, rising-edge.
- `Reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a multiply; sampled only in IDLE.
- `multiplicand`  in  WIDTH: S operand, captured when start is accepted.
- `multiplier`  in  WIDTH: B operand, captured when start is accepted.
- `add_x`  out  WIDTH+1: adder x input, equal to `{A[msb], A}`.
- `add_y`  out  WIDTH+1: adder y input.
  - Equal to `{S[msb], S}`.
  - Bitwise-inverted on the subtract step.
- `add_cin`  out  1: adder z input; 1 only on the subtract step.
- `add_s`  in  WIDTH+1: adder sum, consumed combinationally.
- `product`  out  2*WIDTH: `{A, B}`.
- `x_bit`  out  1: sign-extension register X.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when the product is valid.

## Operation
- States: IDLE, ADD, SHIFT, DONE.
- Reset values:
  - State is IDLE; A, B, S, X and the 3-bit count are all 0.
  - Outputs: `product`=0, `x_bit`=0, `busy`=0, `done`=0, `add_x`=0, `add_y`=0, `add_cin`=0.
- IDLE: on `start`=1, load A=0, X=0, B=`multiplier`, S=`multiplicand`, count=0, then go to ADD. The product registers are overwritten only at this point; otherwise they hold.
- ADD:
  - The subtract step is ADD with count==WIDTH-1. It drives `add_y`=~`{S[msb],S}` and `add_cin`=1.
  - If B[0]=1, `{X, A}` <= `add_s`.
  - If B[0]=0, A holds and X <= A[msb].
  - Next state is SHIFT.
- SHIFT: `{X, A, B}` <= `{X, X, A, B[WIDTH-1:1]}` (arithmetic right shift, X retained).
  - If count==WIDTH-1, go to DONE; otherwise count++ and go to ADD.
- DONE: `done`=1 for this single cycle, then go to IDLE.
- Arithmetic is 9-bit two's complement throughout; the adder's `cout` is ignored. The full range is exact, including −128×−128 = +16384.
- `start` while `busy` is ignored; no queuing.
- `Reset` mid-operation: on the next edge all state returns to reset values and no `done` is emitted.
- `Reset` and `start` asserted together: `Reset` wins.

## Timing
- Let `start` be sampled at edge T0.
- ADD occupies cycles after T0, T0+2, …, T0+14; SHIFT occupies cycles after T0+1, …, T0+15.
- `done` is high during the cycle after edge T0+16. `product` is valid from that cycle and holds until the next accepted `start`.
- Back-to-back operation: `start` asserted in the cycle after DONE is accepted, giving 18 cycles per product.
- The adder path is combinational from the registers through the ripple adder and back into `add_s` within one cycle. No adder pipelining.

## Configuration
- `MULT_SEQ_SKIP_EN` defined:
  - In ADD with B[0]=0, the block performs the SHIFT action directly in that cycle and advances count or goes to DONE.
  - Latency (`start` edge to `done` cycle) = WIDTH + popcount(`multiplier`) + 1 edges.
- Not defined: fixed 17-edge latency as above.
- Results are identical with and without the macro.

## Structure
- Package `mult_pkg` holds:
  - `WIDTH_DEFAULT`;
  - the state enum `mult_state_t` {IDLE, ADD, SHIFT, DONE};
  - localparam `LAST_ITER = WIDTH-1`.
- One sub-module: `mult_shift_reg`, the (2*WIDTH+1)-bit `{X,A,B}` register.
  - Supports synchronous clear, parallel load of A/X and of B, and arithmetic right shift.
  - Controlled by `load_ax`, `load_b`, `shift` and `clear`.
- The FSM and adder-input muxing stay in `mult_seq_ctrl`.

## Test plan
- Positive: `multiplicand`=8'h07, `multiplier`=8'h03 → `product`=16'h0015, `x_bit`=0, `done` exactly at T0+16 (without the macro).
- Negative multiplicand: 8'hF9 (−7) × 8'h03 → 16'hFFEB (−21).
- Negative multiplier, exercising the subtract step: 8'h03 × 8'hFE (−2) → 16'hFFFA (−6), with `add_cin`=1 only in the final ADD.
- Extreme values: 8'h80 × 8'h80 → 16'h4000; 8'h7F × 8'h80 → 16'hC080.
- Reset mid-operation: `Reset` pulsed at T0+5 → `busy`=0 and `product`=0 next cycle, no `done`. A `start` pulse at T0+3 with no reset is ignored and the original result is delivered.
- `MULT_SEQ_SKIP_EN` latency: `multiplier`=8'h00 → `done` at T0+8, product 0. `multiplier`=8'hFF with `multiplicand`=8'h05 → `done` at T0+16, product 16'hFFFB.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential add-shift multiplier.
package mult_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned LAST_ITER     = WIDTH_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_shift_reg.sv
// The {X, A, B} register: synchronous clear, parallel load of X/A and of B,
// and arithmetic right shift that keeps X.
module mult_shift_reg
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load_ax,
  input  logic [WIDTH:0]     ax_in,
  input  logic               load_b,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               shift,
  output logic [2*WIDTH:0]   q
);

  // Clear has priority, then shift, then the independent parallel loads.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift) begin
      q <= {q[2*WIDTH], q[2*WIDTH:1]};
    end else begin
      if (load_ax) q[2*WIDTH:WIDTH] <= ax_in;
      if (load_b)  q[WIDTH-1:0]     <= b_in;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Add-shift controller for the signed multiplier; drives an external ripple adder.
// Define MULT_SEQ_SKIP_EN to fold the shift into ADD when B[0] is 0.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [WIDTH:0]       add_x,
  output logic [WIDTH:0]       add_y,
  output logic                 add_cin,
  input  logic [WIDTH:0]       add_s,
  output logic [2*WIDTH-1:0]   product,
  output logic                 x_bit,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] s_reg;
  logic [2*WIDTH:0] xab;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH:0]   ax_in;
  logic             load_ax, load_b, shift, last_iter, sub_step;

  assign a_reg     = xab[2*WIDTH-1:WIDTH];
  assign b_reg     = xab[WIDTH-1:0];
  assign last_iter = (count == CNT_LAST);
  assign sub_step  = (state == ADD) && last_iter;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      s_reg <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (state == IDLE && start) s_reg <= multiplicand;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load_ax   = 1'b0;
    load_b    = 1'b0;
    shift     = 1'b0;
    ax_in     = add_s;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ADD;
          count_nxt = '0;
          load_ax   = 1'b1;
          load_b    = 1'b1;
          ax_in     = '0;
        end
      end
      ADD: begin
        if (b_reg[0]) begin
          load_ax   = 1'b1;
          state_nxt = SHIFT;
        end else begin
`ifdef MULT_SEQ_SKIP_EN
          // X already equals A[msb] here, so the shift alone is equivalent.
          shift = 1'b1;
          if (last_iter) begin
            state_nxt = DONE;
          end else begin
            count_nxt = count + CNT_W'(1);
            state_nxt = ADD;
          end
`else
          load_ax   = 1'b1;
          ax_in     = {a_reg[WIDTH-1], a_reg};
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end else begin
          count_nxt = count + CNT_W'(1);
          state_nxt = ADD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mult_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk     (Clk),
    .clear   (Reset),
    .load_ax (load_ax),
    .ax_in   (ax_in),
    .load_b  (load_b),
    .b_in    (multiplier),
    .shift   (shift),
    .q       (xab)
  );

  // Final iteration subtracts S to weight the multiplier sign bit negatively.
  assign add_x   = {a_reg[WIDTH-1], a_reg};
  assign add_y   = {s_reg[WIDTH-1], s_reg} ^ {(WIDTH+1){sub_step}};
  assign add_cin = sub_step;
  assign product = xab[2*WIDTH-1:0];
  assign x_bit   = xab[2*WIDTH];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl with a behavioural ripple adder attached.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int unsigned W = WIDTH_DEFAULT;
`ifdef MULT_SEQ_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [W:0]     add_x, add_y, add_s;
  logic           add_cin;
  logic [2*W-1:0] product;
  logic           x_bit, busy, done;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
  } exp_t;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           xb;
    logic           busy0;
    logic           done_after;
    logic           timeout;
    int             lat;
    int             cin;
  } obs_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  assign add_s = add_x + add_y + (W+1)'(add_cin);

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_x        (add_x),
    .add_y        (add_y),
    .add_cin      (add_cin),
    .add_s        (add_s),
    .product      (product),
    .x_bit        (x_bit),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] mc, input logic [W-1:0] mr);
    int a;
    int b;
    a = int'($signed(mc));
    b = int'($signed(mr));
    return (2*W)'(a * b);
  endfunction

  function automatic int exp_lat(input logic [W-1:0] mr);
    return SKIP ? int'(W) + $countones(mr) : 2 * int'(LAST_ITER + 1);
  endfunction

  task automatic push_exp(input logic [W-1:0] mc, input logic [W-1:0] mr);
    exp_t e;
    e.prod = exp_prod(mc, mr);
    e.lat  = exp_lat(mr);
    sb.push_back(e);
  endtask

  // Called just after the accepting edge; returns at the negedge of the done cycle.
  task automatic wait_done(input int glitch_at, inout obs_t o);
    int n = 0;
    bit fin = 1'b0;
    while (!fin) begin
      @(negedge Clk);
      if (n == 0) begin
        start   = 1'b0;
        o.busy0 = busy;
      end
      if (glitch_at != 0 && n == glitch_at - 1) begin
        start        = 1'b1;
        multiplicand = ~multiplicand;
        multiplier   = ~multiplier;
      end
      if (glitch_at != 0 && n == glitch_at) start = 1'b0;
      if (add_cin) o.cin++;
      if (done) begin
        o.prod = product;
        o.xb   = x_bit;
        o.lat  = n;
        fin    = 1'b1;
      end else if (n > 60) begin
        o.timeout = 1'b1;
        fin       = 1'b1;
      end else begin
        @(posedge Clk);
        n++;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] mc, input logic [W-1:0] mr, input int glitch_at,
                       output obs_t o);
    o = '{prod: '0, xb: 1'b0, busy0: 1'b0, done_after: 1'b0, timeout: 1'b0, lat: 0, cin: 0};
    @(negedge Clk);
    start        = 1'b1;
    multiplicand = mc;
    multiplier   = mr;
    push_exp(mc, mr);
    @(posedge Clk);
    wait_done(glitch_at, o);
    @(posedge Clk);
    @(negedge Clk);
    o.done_after = done;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({product, x_bit, busy, done, add_x, add_y, add_cin} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got prod=%h x=%b busy=%b done=%b ax=%h ay=%h cin=%b want all 0",
               product, x_bit, busy, done, add_x, add_y, add_cin);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] mcs [9] = '{8'h07, 8'hF9, 8'h03, 8'h80, 8'h7F, 8'h00, 8'h05, 8'hFF, 8'h00};
    logic [W-1:0] mrs [9] = '{8'h03, 8'h03, 8'hFE, 8'h80, 8'h80, 8'h5A, 8'hFF, 8'hFF, 8'h00};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      logic [W-1:0] mc, mr;
      if (i < 9) begin
        mc = mcs[i];
        mr = mrs[i];
      end else begin
        mc = W'($urandom);
        mr = W'($urandom);
      end
      do_op(mc, mr, 0, o);
      e = sb.pop_front();
      n_cmp++;
      if (o.timeout || o.prod !== e.prod) begin
        n_bad++;
        $display("FAIL product[%h*%h]: got %h (timeout=%b) want %h", mc, mr, o.prod, o.timeout, e.prod);
      end
      n_cmp++;
      if (o.xb !== e.prod[2*W-1]) begin
        n_bad++;
        $display("FAIL x_bit[%h*%h]: got %b want %b", mc, mr, o.xb, e.prod[2*W-1]);
      end
      n_cmp++;
      if (o.lat != e.lat) begin
        n_bad++;
        $display("FAIL latency[%h*%h]: got %0d want %0d", mc, mr, o.lat, e.lat);
      end
      n_cmp++;
      if (o.cin != 1) begin
        n_bad++;
        $display("FAIL cin_cycles[%h*%h]: got %0d want 1", mc, mr, o.cin);
      end
      n_cmp++;
      if (o.busy0 !== 1'b1 || o.done_after !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_done_pulse[%h*%h]: got busy=%b done_after=%b want 1/0",
                 mc, mr, o.busy0, o.done_after);
      end
    end
  endtask

  task automatic test_busy_start();
    obs_t o;
    exp_t e;
    do_op(8'h07, 8'h03, 3, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.timeout || o.prod !== e.prod || o.lat != e.lat) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got prod=%h lat=%0d want prod=%h lat=%0d",
               o.prod, o.lat, e.prod, e.lat);
    end
    n_cmp++;
    if (o.done_after !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_requeue: got done=%b after result want 0", o.done_after);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    exp_t e1, e2;
    o1 = '{prod: '0, xb: 1'b0, busy0: 1'b0, done_after: 1'b0, timeout: 1'b0, lat: 0, cin: 0};
    o2 = o1;
    @(negedge Clk);
    start        = 1'b1;
    multiplicand = 8'h80;
    multiplier   = 8'h7F;
    push_exp(8'h80, 8'h7F);
    @(posedge Clk);
    wait_done(0, o1);
    e1 = sb.pop_front();
    start        = 1'b1;
    multiplicand = 8'hF9;
    multiplier   = 8'hF9;
    push_exp(8'hF9, 8'hF9);
    @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0/0", busy, done);
    end
    @(posedge Clk);
    wait_done(0, o2);
    e2 = sb.pop_front();
    n_cmp++;
    if (o1.timeout || o1.prod !== e1.prod || o1.lat != e1.lat) begin
      n_bad++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat %0d", o1.prod, o1.lat, e1.prod, e1.lat);
    end
    n_cmp++;
    if (o2.timeout || o2.prod !== e2.prod || o2.lat != e2.lat || o2.busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: got %h lat %0d busy=%b want %h lat %0d busy=1",
               o2.prod, o2.lat, o2.busy0, e2.prod, e2.lat);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge Clk);
    start        = 1'b1;
    multiplicand = 8'h7F;
    multiplier   = 8'h7F;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b0 || product !== '0 || x_bit !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b prod=%h x=%b done=%b want 0/0000/0/0",
               busy, product, x_bit, done);
    end
    Reset = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      if (done) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: got %0d done cycles want 0", dones);
    end
    // Reset and start on the same edge: reset must win.
    Reset        = 1'b1;
    start        = 1'b1;
    multiplicand = 8'h11;
    multiplier   = 8'h22;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || product !== '0) begin
      n_bad++;
      $display("FAIL reset_beats_start: got busy=%b prod=%h want 0/0000", busy, product);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
